// File: rtl/pq_pkg.sv
// Shared priority-queue types and the width-generic key comparison.
package pq_pkg;
  typedef enum logic {MIN_PQ = 1'b0, MAX_PQ = 1'b1} pq_type_t;

  localparam logic CELL_EMPTY_VALID = 1'b0;

  // "a beats b": strict, so equal keys never overtake one another.
  function automatic logic cmp_key_gt(pq_type_t t, logic [63:0] a, logic [63:0] b);
    return (t == MAX_PQ) ? (a > b) : (a < b);
  endfunction
endpackage

// File: rtl/pq_sr_cell.sv
// One storage position of the shift-register priority queue.
module pq_sr_cell
  import pq_pkg::*;
#(
  parameter int       KEY_WIDTH = 4,
  parameter int       VAL_WIDTH = 4,
  parameter pq_type_t PQ_TYPE   = MAX_PQ,
  localparam int      KVW       = KEY_WIDTH + VAL_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_enq,
  input  logic           op_deq,
  input  logic           op_rep,
  input  logic           op_flush,
  input  logic [KVW-1:0] kv_in,
  input  logic           prev_v,
  input  logic [KVW-1:0] prev_kv,
  input  logic           next_v,
  input  logic [KVW-1:0] next_kv,
  input  logic           ins_prev,
  output logic           ins,
  output logic           q_v,
  output logic [KVW-1:0] q_kv
);
  logic [KEY_WIDTH-1:0] new_key, own_key, next_key;

  assign new_key  = kv_in[KVW-1:VAL_WIDTH];
  assign own_key  = q_kv[KVW-1:VAL_WIDTH];
  assign next_key = next_kv[KVW-1:VAL_WIDTH];

  // On replace the head is leaving, so compare against the shifted view.
  always_comb begin
    ins = 1'b0;
    if (op_rep)
      ins = !next_v || cmp_key_gt(PQ_TYPE, 64'(new_key), 64'(next_key));
    else
      ins = !q_v || cmp_key_gt(PQ_TYPE, 64'(new_key), 64'(own_key));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_v  <= CELL_EMPTY_VALID;
      q_kv <= '0;
    end else if (op_flush) begin
      q_v  <= CELL_EMPTY_VALID;
      q_kv <= '0;
    end else if (op_enq) begin
      if (ins && !ins_prev) begin
        q_v  <= 1'b1;
        q_kv <= kv_in;
      end else if (ins_prev) begin
        q_v  <= prev_v;
        q_kv <= prev_kv;
      end
    end else if (op_deq) begin
      q_v  <= next_v;
      q_kv <= next_kv;
    end else if (op_rep) begin
      if (ins && !ins_prev) begin
        q_v  <= 1'b1;
        q_kv <= kv_in;
      end else if (!ins) begin
        q_v  <= next_v;
        q_kv <= next_kv;
      end
    end
  end
endmodule

// File: rtl/pq_sr_param.sv
// Parametrised shift-register priority queue: op decode, occupancy, flags, head mapping.
module pq_sr_param
  import pq_pkg::*;
#(
  parameter int       KEY_WIDTH = 4,
  parameter int       VAL_WIDTH = 4,
  parameter int       CAPACITY  = 15,
  parameter pq_type_t PQ_TYPE   = MAX_PQ,
  parameter int       CNT_WIDTH = $clog2(CAPACITY + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enq,
  input  logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_in,
  input  logic                           deq,
  input  logic                           flush,
  output logic [KEY_WIDTH+VAL_WIDTH-1:0] kv_out,
  output logic                           out_valid,
  output logic [CNT_WIDTH-1:0]           count,
  output logic                           full,
  output logic                           empty,
  output logic                           ovf,
  output logic                           unf
);
  localparam int KVW = KEY_WIDTH + VAL_WIDTH;

  // Index i+1 holds cell i; both ends are permanently empty neighbours.
  logic           cv  [0:CAPACITY+1];
  logic [KVW-1:0] ckv [0:CAPACITY+1];
  logic           ins_c [0:CAPACITY];

  logic op_enq, op_deq, op_rep, ovf_nxt, unf_nxt;

  assign cv[0]           = CELL_EMPTY_VALID;
  assign ckv[0]          = '0;
  assign cv[CAPACITY+1]  = CELL_EMPTY_VALID;
  assign ckv[CAPACITY+1] = '0;
  assign ins_c[0]        = 1'b0;

  assign full  = (count == CNT_WIDTH'(CAPACITY));
  assign empty = (count == '0);

  // enq+deq on an empty queue degrades to a plain insert.
  always_comb begin
    op_enq  = !flush && enq && ((!deq && !full) || (deq && empty));
    op_deq  = !flush && deq && !enq && !empty;
    op_rep  = !flush && enq && deq && !empty;
    ovf_nxt = !flush && enq && !deq && full;
    unf_nxt = !flush && deq && empty;
  end

  for (genvar i = 0; i < CAPACITY; i++) begin : g_cell
    pq_sr_cell #(
      .KEY_WIDTH(KEY_WIDTH),
      .VAL_WIDTH(VAL_WIDTH),
      .PQ_TYPE  (PQ_TYPE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .op_enq  (op_enq),
      .op_deq  (op_deq),
      .op_rep  (op_rep),
      .op_flush(flush),
      .kv_in   (kv_in),
      .prev_v  (cv[i]),
      .prev_kv (ckv[i]),
      .next_v  (cv[i+2]),
      .next_kv (ckv[i+2]),
      .ins_prev(ins_c[i]),
      .ins     (ins_c[i+1]),
      .q_v     (cv[i+1]),
      .q_kv    (ckv[i+1])
    );
  end

  assign kv_out    = ckv[1];
  assign out_valid = cv[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      ovf <= ovf_nxt;
      unf <= unf_nxt;
      if (flush)       count <= '0;
      else if (op_enq) count <= count + 1'b1;
      else if (op_deq) count <= count - 1'b1;
    end
  end
endmodule

// File: tb/tb_pq_sr_param.sv
// Directed checks of pq_sr_param: a MAX queue and a MIN queue sharing one stimulus stream.
module tb_pq_sr_param;
  import pq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enq = 1'b0, deq = 1'b0, flush = 1'b0;
  logic [7:0] kv_in = '0;

  logic [7:0] kv_x, kv_n;
  logic       ov_x, ov_n, full_x, full_n, empty_x, empty_n;
  logic       ovf_x, ovf_n, unf_x, unf_n;
  logic [2:0] cnt_x, cnt_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pq_sr_param #(.KEY_WIDTH(4), .VAL_WIDTH(4), .CAPACITY(4), .PQ_TYPE(MAX_PQ)) dut_max (
    .clk(clk), .rst(rst), .enq(enq), .kv_in(kv_in), .deq(deq), .flush(flush),
    .kv_out(kv_x), .out_valid(ov_x), .count(cnt_x), .full(full_x), .empty(empty_x),
    .ovf(ovf_x), .unf(unf_x));

  pq_sr_param #(.KEY_WIDTH(4), .VAL_WIDTH(4), .CAPACITY(4), .PQ_TYPE(MIN_PQ)) dut_min (
    .clk(clk), .rst(rst), .enq(enq), .kv_in(kv_in), .deq(deq), .flush(flush),
    .kv_out(kv_n), .out_valid(ov_n), .count(cnt_n), .full(full_n), .empty(empty_n),
    .ovf(ovf_n), .unf(unf_n));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one operation across a clock edge; returns 1ns after the edge.
  task automatic op(input logic e, input logic d, input logic f, input logic [7:0] kv);
    enq = e; deq = d; flush = f; kv_in = kv;
    @(posedge clk); #1;
    enq = 1'b0; deq = 1'b0; flush = 1'b0; kv_in = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // 1. reset state and deq on empty
    #2;
    chk("rst_kv", 32'(kv_x), 32'h00);
    chk("rst_ov", 32'(ov_x), 32'd0);
    chk("rst_cnt", 32'(cnt_x), 32'd0);
    chk("rst_empty", 32'(empty_x), 32'd1);
    chk("rst_full", 32'(full_x), 32'd0);
    chk("rst_ovf", 32'(ovf_x), 32'd0);
    chk("rst_unf", 32'(unf_x), 32'd0);
    #20 rst = 1'b0;
    @(posedge clk); #1;
    op(0, 1, 0, 8'h00);
    chk("unf_pulse", 32'(unf_x), 32'd1);
    chk("unf_empty", 32'(empty_x), 32'd1);
    chk("unf_cnt", 32'(cnt_x), 32'd0);
    chk("unf_ov", 32'(ov_x), 32'd0);
    idle();
    chk("unf_clear", 32'(unf_x), 32'd0);

    // 2. sorted insert, overflow, ordered drain
    op(1, 0, 0, 8'h31);
    op(1, 0, 0, 8'h92);
    chk("ins_head9", 32'(kv_x), 32'h92);
    op(1, 0, 0, 8'h03);
    op(1, 0, 0, 8'hF4);
    chk("full_head", 32'(kv_x), 32'hF4);
    chk("full_cnt", 32'(cnt_x), 32'd4);
    chk("full_flag", 32'(full_x), 32'd1);
    op(1, 0, 0, 8'h75);
    chk("ovf_pulse", 32'(ovf_x), 32'd1);
    chk("ovf_head", 32'(kv_x), 32'hF4);
    chk("ovf_cnt", 32'(cnt_x), 32'd4);
    idle();
    chk("ovf_clear", 32'(ovf_x), 32'd0);
    op(0, 1, 0, 8'h00);
    chk("drain1", 32'(kv_x), 32'h92);
    op(0, 1, 0, 8'h00);
    chk("drain2", 32'(kv_x), 32'h31);
    op(0, 1, 0, 8'h00);
    chk("drain3", 32'(kv_x), 32'h03);
    chk("drain3_cnt", 32'(cnt_x), 32'd1);
    op(0, 1, 0, 8'h00);
    chk("drain_empty", 32'(empty_x), 32'd1);
    chk("drain_ov", 32'(ov_x), 32'd0);
    chk("drain_unf", 32'(unf_x), 32'd0);

    // 3. FIFO among equal keys, MAX then MIN
    op(0, 0, 1, 8'h00);
    op(1, 0, 0, 8'h51);
    op(1, 0, 0, 8'h52);
    op(1, 0, 0, 8'h53);
    chk("tie_h1", 32'(kv_x), 32'h51);
    op(0, 1, 0, 8'h00);
    chk("tie_h2", 32'(kv_x), 32'h52);
    op(0, 1, 0, 8'h00);
    chk("tie_h3", 32'(kv_x), 32'h53);
    op(0, 0, 1, 8'h00);
    op(1, 0, 0, 8'h51);
    op(1, 0, 0, 8'h22);
    op(1, 0, 0, 8'h53);
    chk("min_h1", 32'(kv_n), 32'h22);
    chk("min_cnt", 32'(cnt_n), 32'd3);
    op(0, 1, 0, 8'h00);
    chk("min_h2", 32'(kv_n), 32'h51);
    op(0, 1, 0, 8'h00);
    chk("min_h3", 32'(kv_n), 32'h53);
    op(0, 0, 1, 8'h00);

    // 4. replace on a full queue
    op(1, 0, 0, 8'hC0);
    op(1, 0, 0, 8'h80);
    op(1, 0, 0, 8'h60);
    op(1, 0, 0, 8'h40);
    op(1, 1, 0, 8'hA7);
    chk("rep_head", 32'(kv_x), 32'hA7);
    chk("rep_cnt", 32'(cnt_x), 32'd4);
    chk("rep_ovf", 32'(ovf_x), 32'd0);
    chk("rep_full", 32'(full_x), 32'd1);
    op(1, 1, 0, 8'h10);
    chk("rep2_head", 32'(kv_x), 32'h80);
    op(0, 1, 0, 8'h00);
    chk("rep2_c1", 32'(kv_x), 32'h60);
    op(0, 1, 0, 8'h00);
    chk("rep2_c2", 32'(kv_x), 32'h40);
    op(0, 1, 0, 8'h00);
    chk("rep2_last", 32'(kv_x), 32'h10);
    op(0, 1, 0, 8'h00);
    chk("rep2_empty", 32'(empty_x), 32'd1);

    // enq+deq on empty: insert, unf pulse
    op(1, 1, 0, 8'h66);
    chk("ed_empty_unf", 32'(unf_x), 32'd1);
    chk("ed_empty_cnt", 32'(cnt_x), 32'd1);
    chk("ed_empty_kv", 32'(kv_x), 32'h66);
    op(0, 1, 0, 8'h00);

    // 5. flush beats enq+deq; key 0 is an ordinary key
    op(1, 0, 0, 8'h11);
    op(1, 0, 0, 8'h22);
    op(1, 0, 0, 8'h33);
    op(1, 1, 1, 8'hEE);
    chk("fl_cnt", 32'(cnt_x), 32'd0);
    chk("fl_empty", 32'(empty_x), 32'd1);
    chk("fl_ovf", 32'(ovf_x), 32'd0);
    chk("fl_unf", 32'(unf_x), 32'd0);
    chk("fl_ov", 32'(ov_x), 32'd0);
    op(1, 0, 0, 8'h09);
    chk("k0_kv", 32'(kv_x), 32'h09);
    chk("k0_ov", 32'(ov_x), 32'd1);
    chk("k0_cnt", 32'(cnt_x), 32'd1);
    op(0, 1, 0, 8'h00);
    chk("k0_empty", 32'(empty_x), 32'd1);
    chk("k0_unf", 32'(unf_x), 32'd0);

    // 6. asynchronous reset between edges
    op(1, 0, 0, 8'h21);
    op(1, 0, 0, 8'h35);
    chk("ar_pre_cnt", 32'(cnt_x), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("ar_cnt", 32'(cnt_x), 32'd0);
    chk("ar_ov", 32'(ov_x), 32'd0);
    chk("ar_kv", 32'(kv_x), 32'h00);
    chk("ar_empty", 32'(empty_x), 32'd1);
    #3 rst = 1'b0;
    idle();
    chk("ar_hold", 32'(cnt_x), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pq_sr_param.md
Name: pq_sr_param

Overview:
Parametrised shift-register hardware priority queue; next generation of the HWPQ shift-register implementation.
- Key/value widths, capacity and MIN/MAX ordering are module parameters rather than package constants.
- Adds per-cell valid bits, so every key value is legal (no KEYINF sentinel), plus FIFO tie-breaking among equal keys, single-cycle replace (enq+deq), flush, occupancy count and error pulses.
- Sits between an HWPQ scheduler front end and the pq_pkg comparison helpers.

Parameters:
KEY_WIDTH, 4, key bits
VAL_WIDTH, 4, payload bits
CAPACITY, 15, number of storage cells (>=2)
PQ_TYPE, MAX_PQ, pq_type_t; MAX_PQ = largest key is head, MIN_PQ = smallest key is head
CNT_WIDTH, $clog2(CAPACITY+1), width of count output

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
enq  in  1  insert kv_in this cycle
kv_in  in  KEY_WIDTH+VAL_WIDTH  {key,value} to insert
deq  in  1  remove head this cycle
flush  in  1  discard all entries
kv_out  out  KEY_WIDTH+VAL_WIDTH  head entry (cell 0), registered
out_valid  out  1  cell 0 holds a valid entry
count  out  CNT_WIDTH  number of valid entries
full  out  1  count == CAPACITY
empty  out  1  count == 0
ovf  out  1  one-cycle pulse: enq dropped (full, no deq)
unf  out  1  one-cycle pulse: deq ignored (empty)

Behaviour:
- Reset (async, rst=1): all cell valids=0, cell data=0, count=0, kv_out=0, out_valid=0, empty=1, full=0, ovf=0, unf=0.
- Storage: cells 0..CAPACITY-1, each {valid,key,value}. Invariants:
  - valid cells are contiguous from cell 0;
  - sorted by priority (cell 0 highest);
  - equal keys kept in arrival order (older nearer head).
- Priority test "a beats b": a.key > b.key for MAX_PQ, a.key < b.key for MIN_PQ; strict, which gives FIFO among equal keys.
- All operations complete in one clock. kv_out, out_valid, count, full and empty reflect the new state the cycle after the edge. No combinational path from inputs to outputs.
- Precedence: flush > (enq,deq) combination.
- flush=1: all valids cleared, count=0; enq/deq the same cycle are ignored and no ovf/unf is raised.
- enq only, not full: each cell i computes ins_i = !valid_i OR new beats cell_i. The first cell with ins_i=1 takes kv_in; every cell after it takes cell i-1; cells before it hold. count+1.
- enq only, full: queue unchanged, ovf=1 for one cycle.
- deq only, not empty: every cell i takes cell i+1; last cell valid=0. count-1.
- deq only, empty: no change, unf=1.
- enq+deq, not empty (replace): head removed and kv_in inserted into the remaining entries in the same cycle. Cell i takes:
  - kv_in if it is the first position where kv_in beats (or valid clears) the shifted view cell_{i+1};
  - cell_{i+1} before that position;
  - unchanged after it.
  count unchanged. Legal when full, with no ovf.
- enq+deq, empty: kv_in is inserted (deq ignored), unf=1, count=1.
- Neither enq nor deq: hold.
- rst asserted mid-operation: immediate clear regardless of clock; the pending operation is lost.
- ovf and unf are registered pulses, high exactly one cycle after the offending edge.

Decomposition:
- pq_pkg additions:
  - function cmp_key_gt(pq_type_t t, logic [63:0] a, b) for width-generic comparison, with callers zero-extending keys;
  - CELL_EMPTY_VALID constant = 1'b0;
  - existing pq_type_t, MIN_PQ, MAX_PQ.
- Sub-module pq_sr_cell (one per position, generate loop):
  - inputs: own, previous and next cell state, kv_in, and the op decode (enq, deq, flush);
  - outputs: ins_i to the next cell and registered cell state.
- Top level holds op decode, count, flags, and cell-0 output mapping.

Test Plan:
1. Reset, then deq with CAPACITY=4, MAX_PQ -> unf pulse 1 cycle, empty=1, count=0, out_valid=0.
2. Enq keys 3,9,0,15 (vals 1,2,3,4) -> kv_out {15,4}, count=4, full=1. Then enq {7,5} -> ovf pulse, contents unchanged. Deqs yield 15,9,3,0, then empty=1.
3. Enq {5,1},{5,2},{5,3} -> deqs return vals 1,2,3 (FIFO ties). Repeat with MIN_PQ, keys 5,2,5 -> order {2},{5,1},{5,3}.
4. Full queue {12,8,6,4}; enq+deq {10,7} -> kv_out {10,7}, count=4, no ovf. Next replace {1,0} -> head 8, last cell {1,0}.
5. Queue holds 3 entries; assert flush with enq+deq high -> count=0, empty=1, no ovf/unf. Key 0 (MAX_PQ) is enqueued and dequeued correctly, with no sentinel clash.
6. Assert rst asynchronously between edges after 2 enqueues -> outputs clear immediately, before the next clk edge.
